// File: rtl/field_halver_pkg.sv
// Shared prime-field constants used by field_halver and field_multiplier.
// Also holds the halver FSM state type.
package field_halver_pkg;

   localparam int F_NBITS = 61;
   localparam logic [F_NBITS-1:0] F_PRIME = 61'h1FFF_FFFF_FFFF_FFFF;
   // (p+1)/2 written so that p+1 never has to fit in F_NBITS bits
   localparam logic [F_NBITS-1:0] F_HALF = (F_PRIME >> 1) + 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RED,
      ST_HALF
   } state_t;

endpackage

// File: rtl/field_halver.sv
// Multiplies a field element by 2^-1 mod p.
// Two stages: reduce into 0..p-1, then halve, adding p first if odd.
module field_halver #(
   parameter int F_NBITS = field_halver_pkg::F_NBITS,
   parameter logic [F_NBITS-1:0] F_PRIME = field_halver_pkg::F_PRIME
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               en,
   input  logic [F_NBITS-1:0] a,
   output logic               ready,
   output logic               ready_pulse,
   output logic [F_NBITS-1:0] c
);

   import field_halver_pkg::*;

   state_t             state_q, state_d;
   logic [F_NBITS-1:0] a_q, a_d;
   logic [F_NBITS-1:0] r_q, r_d;
   logic [F_NBITS-1:0] c_q, c_d;
   logic               pulse_q, pulse_d;
   logic [F_NBITS:0]   sum;

   // One extra bit keeps the carry of r + p when r is odd
   always_comb begin
      sum = {1'b0, r_q};
      if (r_q[0]) begin
         sum = {1'b0, r_q} + {1'b0, F_PRIME};
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      r_d     = r_q;
      c_d     = c_q;
      pulse_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (en) begin
               a_d     = a;
               state_d = ST_RED;
            end
         end
         ST_RED: begin
            if (a_q >= F_PRIME) begin
               r_d = a_q - F_PRIME;
            end else begin
               r_d = a_q;
            end
            state_d = ST_HALF;
         end
         ST_HALF: begin
            c_d     = sum[F_NBITS:1];
            pulse_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstb) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         r_q     <= r_d;
         c_q     <= c_d;
         pulse_q <= pulse_d;
      end
   end

   assign ready       = (state_q == ST_IDLE);
   assign ready_pulse = pulse_q;
   assign c           = c_q;

endmodule

// File: tb/tb_field_halver.sv
// Self-checking bench for field_halver: directed table, corner sequences,
// and back-to-back random operands against a modular-arithmetic model.
module tb_field_halver;

   localparam int N = 61;
   localparam logic [N-1:0] P = 61'h1FFF_FFFF_FFFF_FFFF;
   localparam logic [N-1:0] HALF = 61'h1000_0000_0000_0000;

   logic         clk;
   logic         rstb;
   logic         en;
   logic [N-1:0] a;
   logic         ready;
   logic         ready_pulse;
   logic [N-1:0] c;

   int vecs;
   int errs;

   field_halver dut (
      .clk        (clk),
      .rstb       (rstb),
      .en         (en),
      .a          (a),
      .ready      (ready),
      .ready_pulse(ready_pulse),
      .c          (c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] c;
      string        name;
   } vec_t;

   // Reference: a * (p+1)/2 mod p using wide plain arithmetic
   function automatic logic [N-1:0] ref_half(input logic [N-1:0] x);
      logic [127:0] prod;
      prod = {67'b0, x} * {67'b0, HALF};
      prod = prod % {67'b0, P};
      return prod[N-1:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!ready) check("ready_timeout", 64'(ready), 64'd1);
   endtask

   // Start one op, then verify ready/pulse on each of the 3 following edges
   task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] exp,
                         input string name);
      wait_ready();
      en = 1'b1;
      a  = x;
      @(negedge clk);
      en = 1'b0;
      a  = '0;
      check({name, "_busy1"}, {62'b0, ready, ready_pulse}, 64'd0);
      @(negedge clk);
      check({name, "_busy2"}, {62'b0, ready, ready_pulse}, 64'd0);
      @(negedge clk);
      check({name, "_pulse"}, {62'b0, ready, ready_pulse}, 64'd3);
      check({name, "_c"}, 64'(c), 64'(exp));
      @(negedge clk);
      check({name, "_pdrop"}, 64'(ready_pulse), 64'd0);
      check({name, "_hold"}, 64'(c), 64'(exp));
   endtask

   vec_t tbl[7];

   initial begin
      logic [N-1:0] exp_c;
      int           issued;
      int           cnt;
      logic [N-1:0] r;

      vecs = 0;
      errs = 0;
      tbl[0] = '{61'h0, 61'h0, "a_zero"};
      tbl[1] = '{61'h2, 61'h1, "a_two"};
      tbl[2] = '{61'h1, 61'h1000_0000_0000_0000, "a_one"};
      tbl[3] = '{61'h1FFF_FFFF_FFFF_FFFE, 61'h0FFF_FFFF_FFFF_FFFF, "a_pm1"};
      tbl[4] = '{61'h1FFF_FFFF_FFFF_FFFF, 61'h0, "a_p"};
      tbl[5] = '{61'h3, 61'h1000_0000_0000_0001, "a_three"};
      tbl[6] = '{61'h0AAA_AAAA_AAAA_AAAA, 61'h0555_5555_5555_5555, "a_even"};

      rstb = 1'b1;
      en   = 1'b1;
      a    = 61'h5;
      repeat (2) @(negedge clk);
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_pulse", 64'(ready_pulse), 64'd0);
      check("rst_c", 64'(c), 64'd0);
      rstb = 1'b0;
      en   = 1'b0;
      @(negedge clk);
      check("rst_en_ignored", 64'(ready), 64'd1);

      for (int i = 0; i < 7; i++) begin
         check({tbl[i].name, "_model"}, 64'(ref_half(tbl[i].a)),
               64'(tbl[i].c));
         run_op(tbl[i].a, tbl[i].c, tbl[i].name);
      end

      // en re-asserted while busy must not disturb the running op
      wait_ready();
      en = 1'b1;
      a  = 61'h2;
      @(negedge clk);
      a = 61'h7;
      @(negedge clk);
      a = 61'h9;
      @(negedge clk);
      check("busy_en_pulse", 64'(ready_pulse), 64'd1);
      check("busy_en_c", 64'(c), 64'd1);
      en = 1'b0;
      @(negedge clk);
      check("busy_en_pdrop", 64'(ready_pulse), 64'd0);

      // Reset mid-operation aborts without a pulse
      run_op(61'h4, 61'h2, "pre_abort");
      en = 1'b1;
      a  = 61'h6;
      @(negedge clk);
      en   = 1'b0;
      rstb = 1'b1;
      @(negedge clk);
      rstb = 1'b0;
      check("abort_ready", 64'(ready), 64'd1);
      check("abort_c", 64'(c), 64'd0);
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (ready_pulse) cnt++;
      end
      check("abort_no_pulse", 64'(cnt), 64'd0);

      // Back-to-back random ops, issuing on every ready_pulse
      wait_ready();
      issued = 0;
      r      = {$urandom, $urandom};
      en     = 1'b1;
      a      = r;
      exp_c  = ref_half(r);
      issued = 1;
      cnt    = 0;
      for (int cyc = 0; cyc < 8000; cyc++) begin
         @(negedge clk);
         cnt++;
         if (ready_pulse) begin
            check("rnd_lat", 64'(cnt), 64'd3);
            check("rnd_c", 64'(c), 64'(exp_c));
            if (issued == 1000) begin
               en = 1'b0;
               break;
            end
            r = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) r = P;
            en     = 1'b1;
            a      = r;
            exp_c  = ref_half(r);
            issued++;
            cnt    = 0;
         end else begin
            if (cnt > 3) begin
               check("rnd_timeout", 64'(cnt), 64'd3);
               en = 1'b0;
               break;
            end
            check("rnd_busy", 64'(ready), 64'd0);
            en = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
         end
      end
      check("rnd_issued", 64'(issued), 64'd1000);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/field_halver.md
FIELD_HALVER -- requirements
Module: field_halver

Interface
REQ-001 Parameter F_NBITS, default 61: field element width in bits; sourced from the shared field package.
REQ-002 Parameter F_PRIME, default 2^61-1 (0x1FFFFFFFFFFFFFFF): field modulus p, odd, p < 2^F_NBITS; sourced from the shared field package.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rstb  input  1: reset; synchronous, active-high (rstb=1 at a rising clk edge resets).
REQ-005 Port en  input  1: start request, sampled at the rising edge.
REQ-006 Port a  input  F_NBITS: operand, any value 0..2^F_NBITS-1.
REQ-007 Port ready  output  1: high when idle and c holds the last result.
REQ-008 Port ready_pulse  output  1: high for exactly one cycle when a new result appears in c.
REQ-009 Port c  output  F_NBITS: registered result, a*2^-1 mod p, always in 0..p-1.

Function
REQ-010 The result SHALL equal a*F_HALF mod p, with F_HALF = (p+1)/2; it SHALL be bit-identical to a field multiplier given b = F_HALF.
REQ-011 Stage 1: r = a-p if a >= p, else r = a (one conditional subtract).
REQ-012 Stage 2: c = r>>1 if r is even; c = (r+p)>>1 if r is odd; the sum uses an F_NBITS+1-bit adder, no overflow loss.
REQ-013 States: IDLE (ready=1), RED (stage 1), HALF (stage 2); en=1 in IDLE at an edge latches a and moves to RED, so ready=0 from the next cycle.
REQ-014 RED -> HALF unconditionally; HALF -> IDLE unconditionally, registering c, setting ready=1 and ready_pulse=1 in the same cycle.
REQ-015 Latency: c valid and ready_pulse high exactly 3 rising edges after the edge that sampled en.
REQ-016 ready_pulse SHALL drop after one cycle even if en is held high; en=1 in that cycle starts a new operation (back-to-back permitted).
REQ-017 en while RED or HALF SHALL be ignored; the latched operand SHALL not change, and a SHALL be don't-care after the start edge.
REQ-018 c SHALL hold its value in IDLE and during an operation until overwritten in HALF.

Reset
REQ-019 On reset: state IDLE, ready=1, ready_pulse=0, c=0, operand register 0.
REQ-020 Reset in RED or HALF SHALL abort the operation without a ready_pulse; reset overrides a simultaneous en.

Structure
REQ-021 The shared field package SHALL hold F_NBITS, F_PRIME and F_HALF, common to field_halver and field_multiplier.
REQ-022 No sub-module is required; the comparator/subtractor and the conditional adder SHALL be inline combinational logic between registers.

Verification
REQ-023 a=0 -> c=0; a=2 -> c=1; each with a single ready_pulse 3 edges after en.
REQ-024 a=1 -> c=0x1000000000000000; a=0x1FFFFFFFFFFFFFFE -> c=0x0FFFFFFFFFFFFFFF.
REQ-025 a=p (0x1FFFFFFFFFFFFFFF) -> c=0.
REQ-026 1000 random a issued back-to-back on ready_pulse, run in parallel with field_multiplier(b=F_HALF) -> outputs equal every time.
REQ-027 en pulsed again while busy -> ignored, c equals the first operand's result; rstb=1 mid-operation -> ready=1, c=0, no ready_pulse.
